// File: rtl/enc8b10b_pkg.sv
// Shared constants and helpers for the pipelined 8b/10b encoder.
// Code words are 10 bits {j,h,g,f,i,e,d,c,b,a}; RD_NEG marks negative running disparity.
package enc8b10b_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  localparam logic       RD_NEG    = 1'b0;

  // K28.0..K28.7 plus K23.7, K27.7, K29.7 and K30.7 are the only legal control codes
  function automatic logic is_legal_k(input logic [7:0] b);
    logic [4:0] x;
    logic [2:0] y;
    x = b[4:0];
    y = b[7:5];
    return (x == 5'd28) ||
           ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  function automatic logic is_balanced6(input logic [5:0] c);
    return ($countones(c) == 32'd3);
  endfunction

endpackage

// File: rtl/enc8b10b_byte.sv
// Combinational single-byte 8b/10b encoder (5b/6b + 3b/4b) with disparity in/out
// and an illegal-control-code flag.
module enc8b10b_byte
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       illegal_k
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k28;
  logic [5:0] w_6b_neg;
  logic [5:0] w_6b;
  logic       w_6b_unbal;
  logic       w_rd_mid;
  logic [3:0] w_4b_neg;
  logic [3:0] w_4b;
  logic       w_4b_unbal;
  logic       w_4b_flip;
  logic       w_a7;

  assign w_x   = data[4:0];
  assign w_y   = data[7:5];
  assign w_k28 = k && (w_x == 5'd28);

  // 5b/6b: RD- code word (abcdei, a at MSB); complemented when entering with RD+
  always_comb begin
    w_6b_neg = 6'b000000;
    if (w_k28) begin
      w_6b_neg = 6'b001111;
    end else begin
      case (w_x)
        5'd0:  w_6b_neg = 6'b100111;  5'd1:  w_6b_neg = 6'b011101;
        5'd2:  w_6b_neg = 6'b101101;  5'd3:  w_6b_neg = 6'b110001;
        5'd4:  w_6b_neg = 6'b110101;  5'd5:  w_6b_neg = 6'b101001;
        5'd6:  w_6b_neg = 6'b011001;  5'd7:  w_6b_neg = 6'b111000;
        5'd8:  w_6b_neg = 6'b111001;  5'd9:  w_6b_neg = 6'b100101;
        5'd10: w_6b_neg = 6'b010101;  5'd11: w_6b_neg = 6'b110100;
        5'd12: w_6b_neg = 6'b001101;  5'd13: w_6b_neg = 6'b101100;
        5'd14: w_6b_neg = 6'b011100;  5'd15: w_6b_neg = 6'b010111;
        5'd16: w_6b_neg = 6'b011011;  5'd17: w_6b_neg = 6'b100011;
        5'd18: w_6b_neg = 6'b010011;  5'd19: w_6b_neg = 6'b110010;
        5'd20: w_6b_neg = 6'b001011;  5'd21: w_6b_neg = 6'b101010;
        5'd22: w_6b_neg = 6'b011010;  5'd23: w_6b_neg = 6'b111010;
        5'd24: w_6b_neg = 6'b110011;  5'd25: w_6b_neg = 6'b100110;
        5'd26: w_6b_neg = 6'b010110;  5'd27: w_6b_neg = 6'b110110;
        5'd28: w_6b_neg = 6'b001110;  5'd29: w_6b_neg = 6'b101110;
        5'd30: w_6b_neg = 6'b011110;  5'd31: w_6b_neg = 6'b101011;
        default: w_6b_neg = 6'b000000;
      endcase
    end
  end

  // D7 is balanced but still alternates with RD
  assign w_6b_unbal = !is_balanced6(w_6b_neg);
  assign w_6b       = (rd_in && (w_6b_unbal || (!w_k28 && (w_x == 5'd7)))) ? ~w_6b_neg : w_6b_neg;
  assign w_rd_mid   = w_6b_unbal ? !rd_in : rd_in;

  // 3b/4b: RD- code word (fghj, f at MSB) with A7 substitution
  always_comb begin
    w_a7 = (w_y == 3'd7) &&
           (k ||
            (!w_rd_mid && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
            ( w_rd_mid && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));
    case (w_y)
      3'd0:    w_4b_neg = 4'b1011;
      3'd1:    w_4b_neg = 4'b1001;
      3'd2:    w_4b_neg = 4'b0101;
      3'd3:    w_4b_neg = 4'b1100;
      3'd4:    w_4b_neg = 4'b1101;
      3'd5:    w_4b_neg = 4'b1010;
      3'd6:    w_4b_neg = 4'b0110;
      3'd7:    w_4b_neg = w_a7 ? 4'b0111 : 4'b1110;
      default: w_4b_neg = 4'b0000;
    endcase
  end

  // K28 also inverts its neutral 4b codes so the comma stays singular
  assign w_4b_unbal = (w_y == 3'd0) || (w_y == 3'd4) || (w_y == 3'd7);
  assign w_4b_flip  = (w_4b_unbal || (w_y == 3'd3)) ? w_rd_mid : (w_k28 && !w_rd_mid);
  assign w_4b       = w_4b_flip ? ~w_4b_neg : w_4b_neg;

  assign code      = {w_4b[0], w_4b[1], w_4b[2], w_4b[3],
                      w_6b[0], w_6b[1], w_6b[2], w_6b[3], w_6b[4], w_6b[5]};
  assign rd_out    = w_4b_unbal ? !w_rd_mid : w_rd_mid;
  assign illegal_k = k && !is_legal_k(data);

endmodule

// File: rtl/enc8b10b_pipe.sv
// NBYTES-wide pipelined 8b/10b encoder: lane 0 first, RD chained across lanes and held in rd_q.
// Optional K28.5 idle insertion and the out_idle port are enabled by ENC_IDLE_INSERT_EN.
module enc8b10b_pipe
  import enc8b10b_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic [NBYTES-1:0]     in_k,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*NBYTES-1:0]  out_data,
  output logic [NBYTES-1:0]     out_err,
`ifdef ENC_IDLE_INSERT_EN
  output logic                  out_idle,
`endif
  output logic                  rd_out
);

  logic                  r_valid;
  logic [10*NBYTES-1:0]  r_data;
  logic [NBYTES-1:0]     r_err;
  logic                  r_rd;
  logic                  w_idle;
  logic                  w_load;
  logic [8*NBYTES-1:0]   w_lane_data;
  logic [NBYTES-1:0]     w_lane_k;
  logic [10*NBYTES-1:0]  w_code;
  logic [NBYTES-1:0]     w_err;
  logic                  w_rd [NBYTES+1];

`ifdef ENC_IDLE_INSERT_EN
  logic                  r_idle;
  assign w_idle   = !in_valid;
  assign out_idle = r_idle;
`else
  assign w_idle   = 1'b0;
`endif

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_ready && (in_valid || w_idle);

  // Lane source: the input beat, or K28.5 on every lane for an idle beat
  always_comb begin
    w_lane_data = in_data;
    w_lane_k    = in_k;
    if (w_idle) begin
      w_lane_data = {NBYTES{K28_5}};
      w_lane_k    = {NBYTES{1'b1}};
    end else begin
      w_lane_data = in_data;
      w_lane_k    = in_k;
    end
  end

  // rd_clr overrides the stored RD as the input disparity of lane 0
  assign w_rd[0] = rd_clr ? RD_NEG : r_rd;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    enc8b10b_byte u_byte (
      .data      (w_lane_data[8*gi +: 8]),
      .k         (w_lane_k[gi]),
      .rd_in     (w_rd[gi]),
      .code      (w_code[10*gi +: 10]),
      .rd_out    (w_rd[gi+1]),
      .illegal_k (w_err[gi])
    );
  end

  // Output register and running disparity; a stalled beat holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {(10*NBYTES){1'b0}};
      r_err   <= {NBYTES{1'b0}};
      r_rd    <= RD_NEG;
`ifdef ENC_IDLE_INSERT_EN
      r_idle  <= 1'b0;
`endif
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_code;
      r_err   <= w_idle ? {NBYTES{1'b0}} : w_err;
      r_rd    <= w_rd[NBYTES];
`ifdef ENC_IDLE_INSERT_EN
      r_idle  <= w_idle;
`endif
    end else begin
      r_valid <= in_ready ? 1'b0 : r_valid;
      r_rd    <= rd_clr ? RD_NEG : r_rd;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_err   = r_err;
  assign rd_out    = r_rd;

endmodule

// File: tb/tb_enc8b10b_pipe.sv
// Self-checking bench for enc8b10b_pipe (NBYTES=2): table-driven 8b/10b model with
// popcount-based disparity tracking, literal anchor beats, backpressure, reset and random traffic.
module tb_enc8b10b_pipe;
  import enc8b10b_pkg::*;

  localparam int NB = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [8*NB-1:0]   in_data = '0;
  logic [NB-1:0]     in_k = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [10*NB-1:0]  out_data;
  logic [NB-1:0]     out_err;
  logic              rd_out;
`ifdef ENC_IDLE_INSERT_EN
  logic              out_idle;
  logic              m_idle;
`endif

  enc8b10b_pipe #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .rd_clr(rd_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
`ifdef ENC_IDLE_INSERT_EN
    .out_idle(out_idle),
`endif
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [5:0] t6 [32];
  logic [3:0] t4d [8];
  logic [3:0] t4k [8];
  logic [7:0] legal_k [12];

  logic              m_valid;
  logic [10*NB-1:0]  m_data;
  logic [NB-1:0]     m_err;
  logic              m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic model_legal(input logic [7:0] b);
    logic hit = 1'b0;
    for (int i = 0; i < 12; i++) if (legal_k[i] == b) hit = 1'b1;
    return hit;
  endfunction

  // Encode one byte from the RD- tables; disparity follows the ones count of each sub-block
  function automatic void model_byte(input logic [7:0] b, input logic k, input logic rd_i,
                                     output logic [9:0] cw, output logic rd_o);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic rd;
    logic k28;
    x = b[4:0];
    y = b[7:5];
    rd = rd_i;
    k28 = k && (x == 5'd28);
    s6 = k28 ? 6'b001111 : t6[x];
    if (rd && (($countones(s6) != 3) || (x == 5'd7 && !k28))) s6 = ~s6;
    if ($countones(s6) != 3) rd = ($countones(s6) > 3);
    if (k28) begin
      s4 = rd_i ? ~t4k[y] : t4k[y];
    end else begin
      s4 = t4d[y];
      if (y == 3'd7 && (k || (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                        (rd && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
        s4 = 4'b0111;
      if (rd && (($countones(s4) != 2) || y == 3'd3)) s4 = ~s4;
    end
    if ($countones(s4) != 2) rd = ($countones(s4) > 2);
    cw = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
    rd_o = rd;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_err = '0; m_rd = 1'b0;
`ifdef ENC_IDLE_INSERT_EN
    m_idle = 1'b0;
`endif
  endtask

  // Advance the model by one clock using the inputs presented to this edge
  task automatic model_clock();
    logic ready, rd, rd2, idle;
    logic [9:0] cw;
    logic [7:0] b;
    logic kk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ready = !m_valid || out_ready;
`ifdef ENC_IDLE_INSERT_EN
    idle = !in_valid;
`else
    idle = 1'b0;
`endif
    if (ready && (in_valid || idle)) begin
      rd = rd_clr ? 1'b0 : m_rd;
      for (int i = 0; i < NB; i++) begin
        b  = idle ? 8'hBC : in_data[8*i +: 8];
        kk = idle ? 1'b1 : in_k[i];
        model_byte(b, kk, rd, cw, rd2);
        m_data[10*i +: 10] = cw;
        m_err[i] = kk && !model_legal(b);
        rd = rd2;
      end
      m_rd = rd;
      m_valid = 1'b1;
`ifdef ENC_IDLE_INSERT_EN
      m_idle = idle;
`endif
    end else begin
      if (ready) m_valid = 1'b0;
      if (rd_clr) m_rd = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_err", 32'(out_err), 32'(m_err));
`ifdef ENC_IDLE_INSERT_EN
      chk("out_idle", 32'(out_idle), 32'(m_idle));
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_lit(input string nm, input logic [15:0] d, input logic [1:0] k,
                          input logic clr, input logic [19:0] ed, input logic [1:0] ee,
                          input logic er);
    in_valid = 1'b1; in_data = d; in_k = k; rd_clr = clr; out_ready = 1'b1;
    cycle();
    chk({nm, "_data"}, 32'(out_data), 32'(ed));
    chk({nm, "_err"}, 32'(out_err), 32'(ee));
    chk({nm, "_rd"}, 32'(rd_out), 32'(er));
  endtask

  initial begin
    t6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
           6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
           6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    t4d = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    t4k = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    legal_k = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                8'hF7, 8'hFB, 8'hFD, 8'hFE};
    model_reset();

    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send_lit("k285x2", 16'hBCBC, 2'b11, 1'b0, {K28_5_RDP, K28_5_RDN}, 2'b00, 1'b0);
    send_lit("d21_5_d0_0", 16'h00B5, 2'b00, 1'b0, {10'h0B9, 10'h155}, 2'b00, 1'b0);
    send_lit("chain", 16'h00BC, 2'b01, 1'b0, {10'h346, 10'h17C}, 2'b00, 1'b1);
    send_lit("rd_clr", 16'hBCBC, 2'b11, 1'b1, {10'h283, 10'h17C}, 2'b00, 1'b0);
    send_lit("illegal_k", 16'hBC00, 2'b11, 1'b0, {10'h17C, 10'h0B9}, 2'b01, 1'b1);
    send_lit("err_clear", 16'hBCBC, 2'b11, 1'b0, {10'h17C, 10'h283}, 2'b00, 1'b1);

    // Backpressure: beat held, in_ready low, then drained in order
    rd_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; out_ready = 1'b0; in_data = 16'(i * 16'h1357 + 16'h0421); in_k = 2'b00;
      cycle();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(out_data), 32'({10'h17C, 10'h283}));
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'($urandom); in_k = 2'b00;
      cycle();
    end

    // Asynchronous reset while a beat is stalled
    in_valid = 1'b1; out_ready = 1'b0; in_data = 16'h1234;
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    send_lit("post_rst", 16'hBCBC, 2'b11, 1'b0, {K28_5_RDP, K28_5_RDN}, 2'b00, 1'b0);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rd_clr    = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_k[i] = 1'b1;
          in_data[8*i +: 8] = ($urandom_range(0, 1) == 1) ? legal_k[$urandom_range(0, 11)]
                                                          : 8'($urandom);
        end else begin
          in_k[i] = 1'b0;
          in_data[8*i +: 8] = 8'($urandom);
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
